// File: rtl/mult64_seq.sv
// Iterative radix-2 shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, signed or unsigned.
// One partial product is accumulated per clock, so a result takes WIDTH+1 edges after Start.
module mult64_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Saida,
  output logic [WIDTH-1:0] SaidaAlta,
  output logic             Ocupado,
  output logic             Pronto,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   ma, mb;
  logic               neg;
  logic [2*WIDTH-1:0] acc, addend, res;
  logic [CW-1:0]      cnt;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;

  // Handshake: Start is a request taken only in IDLE (operands sampled on that edge);
  // Pronto is a one-cycle completion pulse with Saida/SaidaAlta already valid; no backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (Start) state_nx = CALC;
      CALC: if (cnt == LAST) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign Ocupado   = (state != IDLE);
  assign Pronto    = (state == DONE);
  assign dbg_state = state;

  // Magnitudes are unsigned WIDTH-bit, so the most negative value maps to 2^(WIDTH-1) cleanly.
  assign a_neg = Signed & A[WIDTH-1];
  assign b_neg = Signed & B[WIDTH-1];
  assign abs_a = a_neg ? (~A + WIDTH'(1)) : A;
  assign abs_b = b_neg ? (~B + WIDTH'(1)) : B;

  assign addend = {{WIDTH{1'b0}}, ma} << cnt;
  assign res    = neg ? (~acc + (2*WIDTH)'(1)) : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ma        <= '0;
      mb        <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      Saida     <= '0;
      SaidaAlta <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          ma  <= abs_a;
          mb  <= abs_b;
          neg <= a_neg ^ b_neg;
          acc <= '0;
          cnt <= '0;
        end
        CALC: begin
          if (mb[0]) acc <= acc + addend;
          mb  <= mb >> 1;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          Saida     <= res[WIDTH-1:0];
          SaidaAlta <= res[2*WIDTH-1:WIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult64_seq.sv
// Directed bench for mult64_seq: latency, signed/unsigned products, busy-Start rejection,
// and asynchronous reset in the middle of an operation.
module tb_mult64_seq;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic         Signed;
  logic [W-1:0] A, B;
  logic [W-1:0] Saida, SaidaAlta;
  logic         Ocupado, Pronto;
  logic [1:0]   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  mult64_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Signed(Signed), .A(A), .B(B),
    .Saida(Saida), .SaidaAlta(SaidaAlta), .Ocupado(Ocupado), .Pronto(Pronto),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to completion; lat is the edge count from the
  // Start-sampling edge to the edge after which Pronto is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int lat, output int busy, output int pulses);
    lat = 0; busy = 0; pulses = 0;
    A = a; B = b; Signed = s; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    if (Ocupado) busy++;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (Ocupado) busy++;
      if (Pronto) begin
        pulses++;
        if (lat == 0) lat = n;
      end
      if (lat != 0 && n > lat) break;
    end
  endtask

  initial begin
    int lat, busy, pulses, n;
    logic [W-1:0] lo, hi;

    reset = 1'b1; Start = 1'b0; Signed = 1'b0; A = '0; B = '0;
    #2;
    check("rst_lo", Saida, 0);
    check("rst_hi", SaidaAlta, 0);
    check("rst_busy", Ocupado, 0);
    check("rst_pronto", Pronto, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Unsigned basic: latency, pulse width, busy duration
    run_op(64'd3, 64'd5, 1'b0, lat, busy, pulses);
    check("u3x5_lat", lat, 65);
    check("u3x5_pulses", pulses, 1);
    check("u3x5_busy", busy, 66);
    check("u3x5_lo", Saida, 15);
    check("u3x5_hi", SaidaAlta, 0);

    run_op(64'd5, 64'd3, 1'b0, lat, busy, pulses);
    check("swap_lo", Saida, 15);
    check("swap_hi", SaidaAlta, 0);

    run_op({W{1'b1}}, {W{1'b1}}, 1'b0, lat, busy, pulses);
    check("umax_lo", Saida, 64'h0000_0000_0000_0001);
    check("umax_hi", SaidaAlta, 64'hFFFF_FFFF_FFFF_FFFE);

    run_op({W{1'b1}}, {W{1'b1}}, 1'b1, lat, busy, pulses);
    check("sm1_lo", Saida, 1);
    check("sm1_hi", SaidaAlta, 0);

    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 1'b1, lat, busy, pulses);
    check("sm7x6_lat", lat, 65);
    check("sm7x6_lo", Saida, 64'hFFFF_FFFF_FFFF_FFD6);
    check("sm7x6_hi", SaidaAlta, 64'hFFFF_FFFF_FFFF_FFFF);

    run_op(64'h8000_0000_0000_0000, 64'd2, 1'b1, lat, busy, pulses);
    check("smin_lo", Saida, 0);
    check("smin_hi", SaidaAlta, 64'hFFFF_FFFF_FFFF_FFFF);

    // Start while busy: second Start at edge 10 and toggling operands must be ignored
    A = 64'd4; B = 64'd4; Signed = 1'b0; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    lat = 0; pulses = 0;
    for (int e = 1; e <= 200; e++) begin
      if (e == 10) begin Start = 1'b1; A = 64'd9; B = 64'd9; end
      else if (e > 10) begin
        Start = 1'b0;
        A = {32'($urandom), 32'($urandom)};
        B = {32'($urandom), 32'($urandom)};
      end
      @(posedge clk); #1;
      if (Pronto) begin pulses++; if (lat == 0) lat = e; end
      if (lat != 0) break;
    end
    check("busy_lat", lat, 65);
    check("busy_pulses", pulses, 1);
    check("busy_lo", Saida, 16);
    check("busy_hi", SaidaAlta, 0);

    // Start held through DONE: ignored there, accepted on the first IDLE cycle
    A = 64'd9; B = 64'd9; Signed = 1'b0; Start = 1'b1;
    @(posedge clk); #1;
    check("done_ign_busy", Ocupado, 0);
    @(posedge clk); #1;
    Start = 1'b0;
    check("done_acc_busy", Ocupado, 1);
    check("hold_lo", Saida, 16);
    lat = 0;
    for (int e = 3; e <= 200; e++) begin
      @(posedge clk); #1;
      if (Pronto) begin lat = e; break; end
    end
    check("held_lat", lat, 67);
    check("held_lo", Saida, 81);
    @(posedge clk); #1;

    // Asynchronous reset mid-operation
    A = 64'd5; B = 64'd5; Signed = 1'b0; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (29) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("mrst_lo", Saida, 0);
    check("mrst_hi", SaidaAlta, 0);
    check("mrst_busy", Ocupado, 0);
    check("mrst_pronto", Pronto, 0);
    @(posedge clk); #2 reset = 1'b0;
    n = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (Pronto || Ocupado) n++;
    end
    check("mrst_quiet", n, 0);

    run_op(64'd2, 64'd8, 1'b0, lat, busy, pulses);
    check("post_lat", lat, 65);
    check("post_lo", Saida, 16);
    check("post_hi", SaidaAlta, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult64_seq.md
Name: mult64_seq

Overview:
- Iterative radix-2 shift-add multiplier for the 64-bit datapath. Supports signed and unsigned operands and produces a 128-bit product split into low and high halves.
- Sits directly upstream of the 4:1 64-bit result-select mux. `Saida` (low half) drives one mux data input, normally input D, selected with code 3'b011.
- Used by the control FSM for MUL/MULH-class operations. The FSM raises `Start` and waits for `Pronto` before selecting this result.

Parameters:
- WIDTH, 64, operand width. Product is 2*WIDTH. Counter width is $clog2(WIDTH)+1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle request. Sampled only in IDLE.
- Signed  input  1  1 = both operands two's complement; 0 = both unsigned. Sampled with Start.
- A  input  WIDTH  multiplicand. Sampled with Start.
- B  input  WIDTH  multiplier. Sampled with Start.
- Saida  output  WIDTH  product bits [WIDTH-1:0]. Registered.
- SaidaAlta  output  WIDTH  product bits [2*WIDTH-1:WIDTH]. Registered.
- Ocupado  output  1  high whenever state != IDLE.
- Pronto  output  1  one-cycle pulse when Saida/SaidaAlta are updated.

Behaviour:
- Reset (async, any state) sets:
  - state = IDLE
  - Saida = 0, SaidaAlta = 0
  - Ocupado = 0, Pronto = 0
  - counter = 0, internal accumulator and operand registers = 0
  - Any in-flight operation is discarded. No Pronto is issued for it.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If Start=1 at edge E0, latch the operands:
    - mA = |A|, mB = |B| when Signed=1; raw A, B otherwise.
    - neg = Signed & (A[WIDTH-1] ^ B[WIDTH-1]).
    - Clear the 2*WIDTH accumulator. counter = 0. Go to CALC.
  - If Start=0, stay in IDLE.
- Magnitude rule: |x| is computed as an unsigned WIDTH-bit value. |-2^(WIDTH-1)| = 2^(WIDTH-1) with no overflow.
- CALC, one iteration per edge (E1..E_WIDTH):
  - If mB[0]=1, add mA (zero-extended) into the accumulator at bit position counter.
  - Shift mB right by one. counter++.
  - At the edge where counter reaches WIDTH, go to FIX. Exactly WIDTH iterations; there is no early termination.
- FIX, at edge E_WIDTH+1:
  - Result = neg ? (two's-complement negate of the 2*WIDTH accumulator) : accumulator.
  - Load Saida = result low half and SaidaAlta = result high half.
  - Pronto = 1. Go to DONE.
- DONE, at edge E_WIDTH+2: Pronto = 0, go to IDLE.
- Latency and throughput:
  - Pronto is high during the cycle after E_WIDTH+1, i.e. WIDTH+1 edges after the Start-sampling edge. WIDTH=64 gives 65 edges.
  - Minimum Start-to-Start spacing is WIDTH+3 cycles. A Start high during DONE is ignored; it is accepted on the first IDLE cycle.
- Start handling: Start, A, B and Signed are ignored in CALC, FIX and DONE. Operand changes mid-operation do not affect the result.
- Output hold: Saida and SaidaAlta hold the last result until the next FIX or a reset. They are not cleared by a new Start.
- Ocupado timing: rises the cycle after E0, falls the cycle after E_WIDTH+2.
- Arithmetic: all sums are 2*WIDTH bits wide with no truncation. Signed=0 treats the MSB as magnitude.
- Operand swap: swapping A and B gives an identical result.

Test Plan:
- Unsigned basic: reset, then Start with A=3, B=5, Signed=0 -> Pronto pulses exactly 65 edges after the Start edge, for one cycle. Saida=15, SaidaAlta=0. Ocupado is high for 66 cycles.
- Unsigned max: A=B=0xFFFF_FFFF_FFFF_FFFF, Signed=0 -> SaidaAlta=0xFFFF_FFFF_FFFF_FFFE, Saida=0x0000_0000_0000_0001.
- Signed negatives:
  - A=B=0xFFFF_FFFF_FFFF_FFFF (-1), Signed=1 -> Saida=1, SaidaAlta=0.
  - A=-7, B=6 -> Saida=0xFFFF_FFFF_FFFF_FFD6 (-42), SaidaAlta=all ones.
- Signed boundary: A=0x8000_0000_0000_0000, B=2, Signed=1 -> Saida=0, SaidaAlta=0xFFFF_FFFF_FFFF_FFFF (-2^64).
- Start while busy: Start with A=4, B=4. At edge 10 pulse Start with A=9, B=9; then toggle A/B every cycle -> exactly one Pronto, with Saida=16. A Start held through DONE is accepted one cycle later and produces 81 after a further 65 edges.
- Reset mid-operation: A=5, B=5; assert reset asynchronously (between edges) at cycle 30 -> all outputs go to 0 immediately, with no Pronto. After release, A=2, B=8 -> Saida=16 with normal latency.
